// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receiver: receive state encoding and the
// constant functions used to size the baud counter and FIFO.
`timescale 1ns/1ps
package uart_rx_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_t;

    // Clock cycles per bit, rounded to the nearest integer.
    function automatic int baud_count(input int clk_hz, input int baud);
        return (clk_hz + baud / 2) / baud;
    endfunction

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/uart_rx_fifo_buf.sv
// Synchronous first-word-fall-through FIFO. The head entry is kept in a
// register so o_data is valid in the same cycle that o_empty falls.
`timescale 1ns/1ps
module uart_rx_fifo_buf
    import uart_rx_pkg::*;
#(
    parameter int G_WIDTH = 8,
    parameter int G_DEPTH = 16
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_push,
    input  logic [G_WIDTH-1:0] i_data,
    input  logic               i_pop,
    output logic [G_WIDTH-1:0] o_data,
    output logic               o_empty,
    output logic               o_full,
    output logic               o_overflow_evt
);

    localparam int AW   = clog2(G_DEPTH);
    localparam int CNTW = AW + 1;

    logic [G_WIDTH-1:0] mem_q [G_DEPTH];
    logic [AW-1:0]      wr_ptr_q;
    logic [AW-1:0]      rd_ptr_q;
    logic [AW-1:0]      rd_ptr_inc;
    logic [CNTW-1:0]    count_q;
    logic [G_WIDTH-1:0] head_q;
    logic               empty;
    logic               full;
    logic               do_pop;
    logic               do_push;

    assign empty          = (count_q == '0);
    assign full           = (count_q == CNTW'(G_DEPTH));
    assign do_pop         = i_pop && !empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign do_push        = i_push && (!full || do_pop);
    assign o_overflow_evt = i_push && full && !do_pop;
    assign rd_ptr_inc     = rd_ptr_q + AW'(1);

    assign o_data  = head_q;
    assign o_empty = empty;
    assign o_full  = full;

    always_ff @(posedge i_clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= i_data;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            head_q   <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_inc;
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CNTW'(1);
                2'b01:   count_q <= count_q - CNTW'(1);
                default: count_q <= count_q;
            endcase
            // Next head: the following stored entry, or the incoming byte when
            // the FIFO would otherwise run dry.
            if (do_pop) begin
                if (count_q == CNTW'(1)) begin
                    if (do_push) begin
                        head_q <= i_data;
                    end
                end else begin
                    head_q <= mem_q[rd_ptr_inc];
                end
            end else if (do_push && empty) begin
                head_q <= i_data;
            end
        end
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receiver (8 data bits, 1 or 2 stop bits) with mid-bit sampling,
// feeding a small FWFT FIFO read by the processor.
//
// state | meaning
// IDLE  | waiting for a synced high-to-low edge on the line
// START | half a bit after the edge, confirm the start bit is still low
// DATA  | sample 8 data bits LSB first, one per bit time
// STOP  | sample G_NSTOP stop bits; push the byte or flag a framing error
`timescale 1ns/1ps
module uart_rx_fifo
    import uart_rx_pkg::*;
#(
    parameter int G_CLK_FREQ_HZ = 100_000_000,
    parameter int G_BAUD        = 115200,
    parameter int G_NSTOP       = 1,
    parameter int G_FIFO_DEPTH  = 16,
    parameter int G_SYNC_STAGES = 2
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_uart_rx,
    input  logic       i_rd,
    input  logic       i_clr,
    output logic [7:0] o_data,
    output logic       o_empty,
    output logic       o_full,
    output logic       o_frame_err,
    output logic       o_overflow
);

    localparam int C_BAUD = baud_count(G_CLK_FREQ_HZ, G_BAUD);
    localparam int C_HALF = C_BAUD / 2;
    localparam int CW     = clog2(C_BAUD) + 1;
    localparam logic [CW-1:0] C_BAUD_LD = CW'(C_BAUD - 1);
    localparam logic [CW-1:0] C_HALF_LD = CW'(C_HALF - 1);

    logic [G_SYNC_STAGES-1:0] sync_q;
    logic                     s_rx;
    logic                     rx_dly_q;
    rx_state_t                state_q;
    logic [CW-1:0]            cnt_q;
    logic                     cnt_zero;
    logic [2:0]               bit_idx_q;
    logic                     stop_idx_q;
    logic                     stop_bad_q;
    logic [7:0]               shift_q;
    logic                     push_q;
    logic                     frame_err_q;
    logic                     overflow_q;
    logic                     overflow_evt;

    assign s_rx     = sync_q[G_SYNC_STAGES-1];
    assign cnt_zero = (cnt_q == '0);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            sync_q   <= '1;
            rx_dly_q <= 1'b1;
        end else begin
            sync_q   <= {sync_q[G_SYNC_STAGES-2:0], i_uart_rx};
            rx_dly_q <= s_rx;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            bit_idx_q   <= '0;
            stop_idx_q  <= 1'b0;
            stop_bad_q  <= 1'b0;
            shift_q     <= '0;
            push_q      <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            push_q      <= 1'b0;
            frame_err_q <= 1'b0;
            if (!cnt_zero) begin
                cnt_q <= cnt_q - CW'(1);
            end
            case (state_q)
                IDLE: begin
                    if (rx_dly_q && !s_rx) begin
                        cnt_q   <= C_HALF_LD;
                        state_q <= START;
                    end
                end
                START: begin
                    if (cnt_zero) begin
                        if (s_rx) begin
                            state_q <= IDLE;
                        end else begin
                            cnt_q     <= C_BAUD_LD;
                            bit_idx_q <= '0;
                            state_q   <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (cnt_zero) begin
                        shift_q   <= {s_rx, shift_q[7:1]};
                        bit_idx_q <= bit_idx_q + 3'd1;
                        cnt_q     <= C_BAUD_LD;
                        if (bit_idx_q == 3'd7) begin
                            stop_idx_q <= 1'b0;
                            stop_bad_q <= 1'b0;
                            state_q    <= STOP;
                        end
                    end
                end
                STOP: begin
                    if (cnt_zero) begin
                        if (stop_idx_q == 1'(G_NSTOP - 1)) begin
                            state_q <= IDLE;
                            if (stop_bad_q || !s_rx) begin
                                frame_err_q <= 1'b1;
                            end else begin
                                push_q <= 1'b1;
                            end
                        end else begin
                            stop_idx_q <= 1'b1;
                            stop_bad_q <= !s_rx;
                            cnt_q      <= C_BAUD_LD;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // A fresh overflow outranks a clear arriving in the same cycle.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            overflow_q <= 1'b0;
        end else if (overflow_evt) begin
            overflow_q <= 1'b1;
        end else if (i_clr) begin
            overflow_q <= 1'b0;
        end
    end

    uart_rx_fifo_buf #(
        .G_WIDTH (8),
        .G_DEPTH (G_FIFO_DEPTH)
    ) u_buf (
        .i_clk          (i_clk),
        .i_rst          (i_rst),
        .i_push         (push_q),
        .i_data         (shift_q),
        .i_pop          (i_rd),
        .o_data         (o_data),
        .o_empty        (o_empty),
        .o_full         (o_full),
        .o_overflow_evt (overflow_evt)
    );

    assign o_frame_err = frame_err_q;
    assign o_overflow  = overflow_q;

endmodule
